input_conditioner: RTL

- Upstream stage of the onehot start/stop/clear control FSM. Conditions the raw, asynchronous control input into the clean level `A` that the FSM samples.
- Function: 2-flop synchroniser, then a debounce state machine with a consecutive-cycle counter, then edge pulses.
- `a_o` connects directly to the FSM `A` input. `a_rise_o`/`a_fall_o` are available to neighbouring logic.

---
 rtl/input_conditioner.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Input conditioner: 2-flop synchroniser, debounce FSM with a consecutive-cycle
// counter, and registered edge pulses. Drives the clean level A of the
// start/stop/clear control FSM.
// Optional macro INPUT_CONDITIONER_GLITCH_CNT_EN adds glitch_cnt_o, a saturating
// count of rejected glitches.

module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5,
    parameter logic        INIT_LEVEL      = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       a_raw_i,
    output logic       a_o,
    output logic       a_rise_o,
    output logic       a_fall_o,
    output logic       stable_o
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt_o
`endif
);

    typedef enum logic [1:0] {
        StStableLo = 2'b00,
        StChkHi    = 2'b01,
        StStableHi = 2'b10,
        StChkLo    = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam state_e           StReset  = INIT_LEVEL ? StStableHi : StStableLo;

    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             stable_q, stable_d;

    // Two-flop synchroniser; only s2_q is ever looked at downstream.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            s1_q <= INIT_LEVEL;
            s2_q <= INIT_LEVEL;
        end else begin
            s1_q <= a_raw_i;
            s2_q <= s1_q;
        end
    end

    // Debounce next-state: a new level must persist DEBOUNCE_CYCLES samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            StStableLo: begin
                if (s2_q) begin
                    state_d = StChkHi;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StChkHi: begin
                if (!s2_q) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableHi;
                    a_d     = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStableHi: begin
                if (!s2_q) begin
                    state_d = StChkLo;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StChkLo: begin
                if (s2_q) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableLo;
                    a_d     = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StStableLo;
                a_d     = 1'b0;
                cnt_d   = '0;
            end
        endcase
        stable_d = (state_d == StStableLo) || (state_d == StStableHi);
    end

    // Debounce state, level, pulse and stable registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q  <= StReset;
            cnt_q    <= '0;
            a_q      <= INIT_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            stable_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            stable_q <= stable_d;
        end
    end

    assign a_o      = a_q;
    assign a_rise_o = rise_q;
    assign a_fall_o = fall_q;
    assign stable_o = stable_q;

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] glitch_q;

    assign abort = ((state_q == StChkHi) && !s2_q) || ((state_q == StChkLo) && s2_q);

    // Saturating count of checks that reverted before committing.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            glitch_q <= 8'd0;
        end else if (abort && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt_o = glitch_q;
`endif

endmodule
